uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small word FIFO in front of it.
// Words pushed on the write side are queued and serialised as
// start / DATA_BITS (LSB first) / optional parity / STOP_BITS frames.
// Frames are sent back to back while the FIFO holds data.

`timescale 1ns/1ps

module uart_tx_fifo #(
   parameter int CLK_DIV    = 4,   // clock cycles per serial bit (2..65535)
   parameter int DATA_BITS  = 8,   // payload bits per frame (5..8)
   parameter int FIFO_DEPTH = 4,   // word slots, power of two (2..256)
   parameter int PARITY     = 0,   // 0 = none, 1 = odd, 2 = even
   parameter int STOP_BITS  = 1    // 1 or 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_BITS-1:0]          wr_data,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          busy,
   output logic                          tx
);

   // ------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = 3;

   localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(CLK_DIV - 1);
   localparam logic [AW:0]      FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
   localparam logic [BIT_W-1:0] LAST_DATA  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP  = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   // ------------------------------------------------------------------
   // FIFO storage and bookkeeping
   // ------------------------------------------------------------------
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        head_reg;
   logic [AW-1:0]        tail_reg;
   logic [AW:0]          level_reg;
   logic                 overflow_reg;

   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] head_word;
   logic                 head_par;

   // ------------------------------------------------------------------
   // Transmitter state
   // ------------------------------------------------------------------
   state_t               state_reg;
   state_t               state_next;
   logic [DIV_W-1:0]     div_reg;
   logic [DIV_W-1:0]     div_next;
   logic [BIT_W-1:0]     bit_reg;
   logic [BIT_W-1:0]     bit_next;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] shift_next;
   logic                 par_reg;
   logic                 par_next;
   logic                 tx_reg;
   logic                 tx_next;
   logic                 div_done;

   // ready depends only on the registered level, so a pop in the same
   // cycle never opens a slot early
   assign wr_ready = (level_reg != FULL_LEVEL);
   assign push     = wr_valid && wr_ready;

   // the head word is captured straight into the shifter on a pop
   assign head_word = mem[head_reg];

   // parity bit is computed once per word when it leaves the FIFO
   assign head_par = (PARITY == 1) ? ~(^head_word) : (^head_word);

   assign level    = level_reg;
   assign overflow = overflow_reg;
   assign busy     = (state_reg != IDLE);
   assign tx       = tx_reg;

   // FIFO storage write port; contents are not reset, only the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail_reg] <= wr_data;
      end
   end

   // FIFO pointers, occupancy and the dropped-write pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg     <= '0;
         tail_reg     <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         // pointers are AW bits wide, so they wrap modulo FIFO_DEPTH
         if (push) begin
            tail_reg <= tail_reg + 1'b1;
         end
         if (pop) begin
            head_reg <= head_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
         overflow_reg <= wr_valid && !wr_ready;
      end
   end

   // transmitter state register; tx is registered so the line is glitch free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         div_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         par_reg   <= 1'b0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         div_reg   <= div_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         par_reg   <= par_next;
         tx_reg    <= tx_next;
      end
   end

   // next-state logic: bit timing, frame sequencing and FIFO pops
   always_comb begin
      state_next = state_reg;
      div_next   = div_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      par_next   = par_reg;
      tx_next    = tx_reg;
      pop        = 1'b0;
      div_done   = (div_reg == '0);

      case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (level_reg != '0) begin
               pop = 1'b1;
            end
         end

         START: begin
            if (div_done) begin
               state_next = DATA;
               div_next   = DIV_LOAD;
               bit_next   = '0;
               tx_next    = shift_reg[0];
            end else begin
               div_next = div_reg - 1'b1;
            end
         end

         DATA: begin
            if (div_done) begin
               div_next = DIV_LOAD;
               if (bit_reg == LAST_DATA) begin
                  bit_next = '0;
                  if (PARITY != 0) begin
                     state_next = PAR;
                     tx_next    = par_reg;
                  end else begin
                     state_next = STOP;
                     tx_next    = 1'b1;
                  end
               end else begin
                  // shifter always presents the current bit at [0]
                  bit_next   = bit_reg + 1'b1;
                  shift_next = shift_reg >> 1;
                  tx_next    = shift_reg[1];
               end
            end else begin
               div_next = div_reg - 1'b1;
            end
         end

         PAR: begin
            if (div_done) begin
               state_next = STOP;
               div_next   = DIV_LOAD;
               bit_next   = '0;
               tx_next    = 1'b1;
            end else begin
               div_next = div_reg - 1'b1;
            end
         end

         STOP: begin
            tx_next = 1'b1;
            if (div_done) begin
               if (bit_reg == LAST_STOP) begin
                  // chain straight into the next frame when data is waiting
                  if (level_reg != '0) begin
                     pop = 1'b1;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  bit_next = bit_reg + 1'b1;
                  div_next = DIV_LOAD;
               end
            end else begin
               div_next = div_reg - 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase

      // a pop always starts a new frame on the same edge
      if (pop) begin
         state_next = START;
         div_next   = DIV_LOAD;
         bit_next   = '0;
         shift_next = head_word;
         par_next   = head_par;
         tx_next    = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three transmitters (no / odd / even parity) driven with
// directed and random words; the serial line is compared cycle by cycle
// against a waveform built from the frame format.

`timescale 1ns/1ps

module tb_uart_tx_fifo;

   localparam int CLK_DIV   = 4;
   localparam int STOP_BITS = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] wr_data  [3];
   logic       wr_valid [3];
   logic       wr_ready [3];
   logic       overflow [3];
   logic [2:0] level    [3];
   logic       busy     [3];
   logic       tx       [3];

   int checks   = 0;
   int failures = 0;

   logic [7:0] words [8];
   bit         exp_wave [$];

   always #5 clk = ~clk;

   // instance gi uses PARITY = gi (0 none, 1 odd, 2 even)
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         uart_tx_fifo #(
            .CLK_DIV   (CLK_DIV),
            .DATA_BITS (8),
            .FIFO_DEPTH(4),
            .PARITY    (gi),
            .STOP_BITS (STOP_BITS)
         ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_data (wr_data[gi]),
            .wr_valid(wr_valid[gi]),
            .wr_ready(wr_ready[gi]),
            .overflow(overflow[gi]),
            .level   (level[gi]),
            .busy    (busy[gi]),
            .tx      (tx[gi])
         );
      end
   endgenerate

   // Reference line waveform for words[0..n-1] sent back to back:
   // start 0, data LSB first, optional parity, stop 1s; CLK_DIV cycles per bit.
   function automatic void build_wave(input int mode, input int n);
      bit frame [$];
      bit p;
      exp_wave.delete();
      for (int w = 0; w < n; w++) begin
         frame.delete();
         frame.push_back(1'b0);
         for (int b = 0; b < 8; b++) frame.push_back(words[w][b]);
         if (mode != 0) begin
            p = ($countones(words[w]) % 2) == 1;   // 1 when data has odd ones
            if (mode == 1) p = ~p;
            frame.push_back(p);
         end
         for (int s = 0; s < STOP_BITS; s++) frame.push_back(1'b1);
         foreach (frame[k])
            for (int c = 0; c < CLK_DIV; c++) exp_wave.push_back(frame[k]);
      end
   endfunction

   function automatic logic wave_bit(input int j);
      if (j >= 0 && j < exp_wave.size()) return exp_wave[j];
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (tx[d] !== 1'b1) begin failures++; $display("FAIL reset_tx dut%0d got=%b want=1", d, tx[d]); end
         checks++;
         if (busy[d] !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d got=%b want=0", d, busy[d]); end
         checks++;
         if (level[d] !== 3'd0) begin failures++; $display("FAIL reset_level dut%0d got=%0d want=0", d, level[d]); end
         checks++;
         if (wr_ready[d] !== 1'b1) begin failures++; $display("FAIL reset_ready dut%0d got=%b want=1", d, wr_ready[d]); end
         checks++;
         if (overflow[d] !== 1'b0) begin failures++; $display("FAIL reset_overflow dut%0d got=%b want=0", d, overflow[d]); end
      end
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (tx[2] !== 1'b1 || busy[2] !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle tx=%b busy=%b want tx=1 busy=0", tx[2], busy[2]);
         end
      end
      $display("test_reset done");
   endtask

   // even parity, 0x55: 44-cycle frame starting one edge after acceptance
   task automatic test_even_frame();
      logic e;
      int   len;
      words[0] = 8'h55;
      build_wave(2, 1);
      len = exp_wave.size();
      checks++;
      if (len != 44) begin failures++; $display("FAIL even_len model=%0d want=44", len); end
      for (int i = 0; i < len + 4; i++) begin
         @(negedge clk);
         e = (i >= 2) ? wave_bit(i - 2) : 1'b1;
         checks++;
         if (tx[2] !== e) begin failures++; $display("FAIL even_tx cycle=%0d got=%b want=%b", i, tx[2], e); end
         checks++;
         if (busy[2] !== (i >= 2 && i < len + 2)) begin
            failures++; $display("FAIL even_busy cycle=%0d got=%b want=%b", i, busy[2], (i >= 2 && i < len + 2));
         end
         if (i == 1) begin
            checks++;
            if (level[2] !== 3'd1) begin failures++; $display("FAIL even_level cycle=1 got=%0d want=1", level[2]); end
         end
         wr_valid[2] = (i == 0);
         wr_data[2]  = words[0];
      end
      $display("test_even_frame word=55 cycles=%0d", len);
   endtask

   // odd and even parity of 0x07: parity bit 0 and 1 respectively
   task automatic test_parity();
      logic e;
      int   len;
      logic pexp;
      for (int d = 1; d <= 2; d++) begin
         words[0] = 8'h07;
         build_wave(d, 1);
         len  = exp_wave.size();
         pexp = (d == 1) ? 1'b0 : 1'b1;
         for (int i = 0; i < len + 4; i++) begin
            @(negedge clk);
            e = (i >= 2) ? wave_bit(i - 2) : 1'b1;
            checks++;
            if (tx[d] !== e) begin failures++; $display("FAIL parity_tx mode=%0d cycle=%0d got=%b want=%b", d, i, tx[d], e); end
            if (i == 2 + 36 || i == 2 + 39) begin
               checks++;
               if (tx[d] !== pexp) begin failures++; $display("FAIL parity_bit mode=%0d got=%b want=%b", d, tx[d], pexp); end
            end
            wr_valid[d] = (i == 0);
            wr_data[d]  = words[0];
         end
         $display("test_parity mode=%0d word=07 parity=%b", d, pexp);
      end
   endtask

   // two writes on consecutive edges: frames with no gap between them
   task automatic test_back_to_back();
      logic e;
      int   len;
      words[0] = 8'h01;
      words[1] = 8'h80;
      build_wave(0, 2);
      len = exp_wave.size();
      for (int i = 0; i < len + 4; i++) begin
         @(negedge clk);
         e = (i >= 2) ? wave_bit(i - 2) : 1'b1;
         checks++;
         if (tx[0] !== e) begin failures++; $display("FAIL b2b_tx cycle=%0d got=%b want=%b", i, tx[0], e); end
         if (i == 2 + 39) begin
            checks++;
            if (tx[0] !== 1'b1) begin failures++; $display("FAIL b2b_stop got=%b want=1", tx[0]); end
         end
         if (i == 2 + 40) begin
            checks++;
            if (tx[0] !== 1'b0) begin failures++; $display("FAIL b2b_start2 got=%b want=0", tx[0]); end
         end
         wr_valid[0] = (i < 2);
         wr_data[0]  = (i < 2) ? words[i] : 8'h00;
      end
      checks++;
      if (level[0] !== 3'd0 || busy[0] !== 1'b0) begin
         failures++; $display("FAIL b2b_end level=%0d busy=%b want level=0 busy=0", level[0], busy[0]);
      end
      $display("test_back_to_back words=01,80 cycles=%0d", len);
   endtask

   // seven writes in a row: five accepted, two dropped with overflow pulses
   task automatic test_overflow();
      logic e;
      int   len;
      int   lvl_tab [6] = '{0, 1, 1, 2, 3, 4};
      for (int w = 0; w < 7; w++) words[w] = 8'($urandom);
      build_wave(0, 5);
      len = exp_wave.size();
      for (int i = 0; i < len + 4; i++) begin
         @(negedge clk);
         e = (i >= 2) ? wave_bit(i - 2) : 1'b1;
         checks++;
         if (tx[0] !== e) begin failures++; $display("FAIL ovf_tx cycle=%0d got=%b want=%b", i, tx[0], e); end
         checks++;
         if (busy[0] !== (i >= 2 && i < len + 2)) begin
            failures++; $display("FAIL ovf_busy cycle=%0d got=%b want=%b", i, busy[0], (i >= 2 && i < len + 2));
         end
         if (i <= 10) begin
            checks++;
            if (overflow[0] !== (i == 6 || i == 7)) begin
               failures++; $display("FAIL ovf_pulse cycle=%0d got=%b want=%b", i, overflow[0], (i == 6 || i == 7));
            end
         end
         if (i <= 8) begin
            checks++;
            if (wr_ready[0] !== !(i >= 5)) begin
               failures++; $display("FAIL ovf_ready cycle=%0d got=%b want=%b", i, wr_ready[0], !(i >= 5));
            end
         end
         if (i <= 5) begin
            checks++;
            if (level[0] !== 3'(lvl_tab[i])) begin
               failures++; $display("FAIL ovf_level cycle=%0d got=%0d want=%0d", i, level[0], lvl_tab[i]);
            end
         end
         wr_valid[0] = (i < 7);
         wr_data[0]  = (i < 7) ? words[i] : 8'h00;
      end
      checks++;
      if (level[0] !== 3'd0) begin failures++; $display("FAIL ovf_end_level got=%0d want=0", level[0]); end
      $display("test_overflow writes=7 frames=5 cycles=%0d", len);
   endtask

   // reset during the third data bit of 0xA5 with two words queued
   task automatic test_reset_midframe();
      logic e;
      words[0] = 8'hA5;
      words[1] = 8'($urandom);
      words[2] = 8'($urandom);
      build_wave(0, 3);
      for (int i = 0; i <= 15; i++) begin
         @(negedge clk);
         e = (i >= 2) ? wave_bit(i - 2) : 1'b1;
         checks++;
         if (tx[0] !== e) begin failures++; $display("FAIL midrst_tx cycle=%0d got=%b want=%b", i, tx[0], e); end
         wr_valid[0] = (i < 3);
         wr_data[0]  = (i < 3) ? words[i] : 8'h00;
      end
      checks++;
      if (level[0] !== 3'd2) begin failures++; $display("FAIL midrst_queued got=%0d want=2", level[0]); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx[0] !== 1'b1 || level[0] !== 3'd0 || busy[0] !== 1'b0 || wr_ready[0] !== 1'b1 || overflow[0] !== 1'b0) begin
         failures++;
         $display("FAIL midrst_immediate tx=%b level=%0d busy=%b ready=%b ovf=%b want 1,0,0,1,0",
                  tx[0], level[0], busy[0], wr_ready[0], overflow[0]);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         checks++;
         if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
            failures++; $display("FAIL midrst_quiet cycle=%0d tx=%b busy=%b want tx=1 busy=0", i, tx[0], busy[0]);
         end
      end
      $display("test_reset_midframe word=A5 quiet_cycles=100");
   endtask

   // random bursts of 1..4 words on every parity mode
   task automatic test_random();
      logic e;
      int   len;
      int   n;
      for (int d = 0; d < 3; d++) begin
         n = $urandom_range(1, 4);
         for (int w = 0; w < n; w++) words[w] = 8'($urandom);
         build_wave(d, n);
         len = exp_wave.size();
         repeat ($urandom_range(0, 3)) @(negedge clk);
         for (int i = 0; i < len + 4; i++) begin
            @(negedge clk);
            e = (i >= 2) ? wave_bit(i - 2) : 1'b1;
            checks++;
            if (tx[d] !== e) begin failures++; $display("FAIL rand_tx mode=%0d cycle=%0d got=%b want=%b", d, i, tx[d], e); end
            checks++;
            if (busy[d] !== (i >= 2 && i < len + 2)) begin
               failures++; $display("FAIL rand_busy mode=%0d cycle=%0d got=%b want=%b", d, i, busy[d], (i >= 2 && i < len + 2));
            end
            wr_valid[d] = (i < n);
            wr_data[d]  = (i < n) ? words[i] : 8'h00;
         end
         checks++;
         if (level[d] !== 3'd0 || wr_ready[d] !== 1'b1) begin
            failures++; $display("FAIL rand_end mode=%0d level=%0d ready=%b want 0,1", d, level[d], wr_ready[d]);
         end
         $display("test_random mode=%0d words=%0d cycles=%0d", d, n, len);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         wr_valid[d] = 1'b0;
         wr_data[d]  = 8'h00;
      end
      test_reset();
      test_even_frame();
      test_parity();
      test_back_to_back();
      test_overflow();
      test_reset_midframe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
